// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter and fetch-control stage of the 64-bit pipeline.
// Sequences the fetch address through boot, increment, stall, branch
// redirect with squash, and sticky halt.
//
// Optional feature macro: FETCH_CNT_EN
//   defined   -> fetch_count counts accepted fetches (saturating)
//   undefined -> fetch_count tied to 0, no counter flops
//
// Ports:
//   clk, reset    clock (rising edge), async active-high reset
//   stall         hazard hold request
//   br_taken      branch resolved taken; br_target is the redirect address
//   halt          stop fetching, sticky until reset
//   pc            current fetch address
//   pc_plus4      pc + 4 (combinational, wraps)
//   fetch_valid   pc is a real fetch this cycle
//   ifid_en       IF/ID load enable
//   squash        IF/ID loads a bubble this cycle
//   misalign      sticky: a misaligned branch target was accepted
//   fetch_count   accepted fetch count
module pc_fetch_ctrl #(
  parameter int unsigned      WIDTH    = 64,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             halt,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             fetch_valid,
  output logic             ifid_en,
  output logic             squash,
  output logic             misalign,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    RUN   = 3'd1,
    STALL = 3'd2,
    FLUSH = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t state;

  // Output decode {fetch_valid, ifid_en, squash} for the state being entered,
  // so the outputs are registered alongside the state.
  function automatic logic [2:0] outs_for(input state_t s);
    case (s)
      RUN:     outs_for = 3'b110;
      STALL:   outs_for = 3'b100;
      FLUSH:   outs_for = 3'b111;
      default: outs_for = 3'b000;
    endcase
  endfunction

  assign pc_plus4 = pc + WIDTH'(4);

  // Fetch FSM: priority halt > br_taken > stall > increment in RUN/STALL/FLUSH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      ifid_en     <= 1'b0;
      squash      <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (halt) begin
            state <= HALT;
            {fetch_valid, ifid_en, squash} <= outs_for(HALT);
          end else begin
            state <= RUN;
            {fetch_valid, ifid_en, squash} <= outs_for(RUN);
          end
        end
        RUN, STALL, FLUSH: begin
          if (halt) begin
            state <= HALT;
            {fetch_valid, ifid_en, squash} <= outs_for(HALT);
          end else if (br_taken) begin
            if (br_target[1:0] == 2'b00) begin
              pc    <= br_target;
              state <= FLUSH;
              {fetch_valid, ifid_en, squash} <= outs_for(FLUSH);
            end else begin
              // Misaligned redirect: freeze with the error flag raised.
              misalign <= 1'b1;
              state    <= HALT;
              {fetch_valid, ifid_en, squash} <= outs_for(HALT);
            end
          end else if (stall) begin
            state <= STALL;
            {fetch_valid, ifid_en, squash} <= outs_for(STALL);
          end else begin
            pc    <= pc_plus4;
            state <= RUN;
            {fetch_valid, ifid_en, squash} <= outs_for(RUN);
          end
        end
        default: begin
          // HALT: everything frozen until reset.
          state <= HALT;
          {fetch_valid, ifid_en, squash} <= outs_for(HALT);
        end
      endcase
    end
  end

`ifdef FETCH_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Saturating count of fetches accepted into IF/ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (fetch_valid && ifid_en && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign fetch_count = cnt;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: a vector table plus hand-written
// multi-cycle sequences, with expectations queued at drive time and popped
// after the clock edge.
module tb_pc_fetch_ctrl;

  localparam logic [63:0] RST_PC = 64'h1000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [63:0] br_target;
  logic        halt;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic        fetch_valid;
  logic        ifid_en;
  logic        squash;
  logic        misalign;
  logic [31:0] fetch_count;

  pc_fetch_ctrl #(
    .WIDTH    (64),
    .RESET_PC (RST_PC),
    .CNT_W    (32)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .halt        (halt),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_valid (fetch_valid),
    .ifid_en     (ifid_en),
    .squash      (squash),
    .misalign    (misalign),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic        fv;
    logic        en;
    logic        sq;
    logic        mis;
  } exp_t;

  typedef struct {
    logic        st;
    logic        br;
    logic [63:0] tgt;
    logic        hl;
    exp_t        e;
  } vec_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_cnt = 0;
  logic        prev_fv = 1'b0;
  logic        prev_en = 1'b0;
  vec_t        vecs[17];

  function automatic exp_t mk_e(input logic [63:0] p, input logic fv, input logic en,
                                input logic sq, input logic mis);
    exp_t r;
    r.pc = p; r.fv = fv; r.en = en; r.sq = sq; r.mis = mis;
    return r;
  endfunction

  function automatic vec_t mk_v(input logic st, input logic br, input logic [63:0] tgt,
                                input logic hl, input exp_t e);
    vec_t r;
    r.st = st; r.br = br; r.tgt = tgt; r.hl = hl; r.e = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] cnt_expect();
`ifdef FETCH_CNT_EN
    return 64'(exp_cnt);
`else
    return 64'd0;
`endif
  endfunction

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input logic st, input logic br, input logic [63:0] tgt,
                      input logic hl, input exp_t e, input string tag);
    exp_t got;
    stall = st; br_taken = br; br_target = tgt; halt = hl;
    sb.push_back(e);
    if (prev_fv && prev_en) exp_cnt++;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, ".pc"},          pc,                   got.pc);
    chk({tag, ".pc_plus4"},    pc_plus4,             got.pc + 64'd4);
    chk({tag, ".fetch_valid"}, 64'(fetch_valid),     64'(got.fv));
    chk({tag, ".ifid_en"},     64'(ifid_en),         64'(got.en));
    chk({tag, ".squash"},      64'(squash),          64'(got.sq));
    chk({tag, ".misalign"},    64'(misalign),        64'(got.mis));
    chk({tag, ".fetch_count"}, 64'(fetch_count),     cnt_expect());
    prev_fv = got.fv;
    prev_en = got.en;
  endtask

  // Assert reset between edges and check its effect before the next edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    stall = 1'b0; br_taken = 1'b0; br_target = '0; halt = 1'b0;
    #1;
    chk({tag, ".rst_pc"},   pc,                RST_PC);
    chk({tag, ".rst_fv"},   64'(fetch_valid),  64'd0);
    chk({tag, ".rst_en"},   64'(ifid_en),      64'd0);
    chk({tag, ".rst_sq"},   64'(squash),       64'd0);
    chk({tag, ".rst_mis"},  64'(misalign),     64'd0);
    chk({tag, ".rst_cnt"},  64'(fetch_count),  64'd0);
    exp_cnt = 0;
    prev_fv = 1'b0;
    prev_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0; halt = 1'b0;

    vecs[0]  = mk_v(0, 0, 64'h0,    0, mk_e(64'h1000, 1, 1, 0, 0)); // BOOT -> RUN
    vecs[1]  = mk_v(0, 0, 64'h0,    0, mk_e(64'h1004, 1, 1, 0, 0));
    vecs[2]  = mk_v(0, 0, 64'h0,    0, mk_e(64'h1008, 1, 1, 0, 0));
    vecs[3]  = mk_v(1, 0, 64'h0,    0, mk_e(64'h1008, 1, 0, 0, 0)); // stall x3
    vecs[4]  = mk_v(1, 0, 64'h0,    0, mk_e(64'h1008, 1, 0, 0, 0));
    vecs[5]  = mk_v(1, 0, 64'h0,    0, mk_e(64'h1008, 1, 0, 0, 0));
    vecs[6]  = mk_v(0, 0, 64'h0,    0, mk_e(64'h100C, 1, 1, 0, 0));
    vecs[7]  = mk_v(0, 1, 64'h2000, 0, mk_e(64'h2000, 1, 1, 1, 0)); // redirect
    vecs[8]  = mk_v(1, 1, 64'h4000, 0, mk_e(64'h4000, 1, 1, 1, 0)); // back-to-back, stall ignored
    vecs[9]  = mk_v(0, 0, 64'h0,    0, mk_e(64'h4004, 1, 1, 0, 0));
    vecs[10] = mk_v(0, 1, 64'h5000, 0, mk_e(64'h5000, 1, 1, 1, 0));
    vecs[11] = mk_v(1, 0, 64'h0,    0, mk_e(64'h5000, 1, 0, 0, 0)); // stall out of FLUSH
    vecs[12] = mk_v(1, 1, 64'h6000, 0, mk_e(64'h6000, 1, 1, 1, 0)); // branch during stall
    vecs[13] = mk_v(0, 0, 64'h0,    0, mk_e(64'h6004, 1, 1, 0, 0));
    vecs[14] = mk_v(0, 1, 64'h7000, 1, mk_e(64'h6004, 0, 0, 0, 0)); // halt beats branch
    vecs[15] = mk_v(0, 1, 64'h8000, 0, mk_e(64'h6004, 0, 0, 0, 0)); // HALT ignores inputs
    vecs[16] = mk_v(1, 0, 64'h0,    0, mk_e(64'h6004, 0, 0, 0, 0));

    #2;
    do_reset("init");

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].st, vecs[i].br, vecs[i].tgt, vecs[i].hl, vecs[i].e,
           $sformatf("vec%0d", i));
    end

    // Reset out of HALT, then a misaligned redirect.
    do_reset("halt_rst");
    step(0, 0, 64'h0,    0, mk_e(64'h1000, 1, 1, 0, 0), "mis0");
    step(0, 1, 64'h4002, 0, mk_e(64'h1000, 0, 0, 0, 1), "mis1");
    step(0, 1, 64'h4000, 0, mk_e(64'h1000, 0, 0, 0, 1), "mis2");
    do_reset("mis_rst");

    // halt during BOOT goes straight to HALT.
    step(0, 0, 64'h0,    1, mk_e(64'h1000, 0, 0, 0, 0), "bh0");
    step(0, 0, 64'h0,    0, mk_e(64'h1000, 0, 0, 0, 0), "bh1");
    do_reset("bh_rst");

    // Wrap from the top of the address space.
    step(0, 0, 64'h0, 0, mk_e(64'h1000, 1, 1, 0, 0), "wr0");
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0, mk_e(64'hFFFF_FFFF_FFFF_FFF8, 1, 1, 1, 0), "wr1");
    step(0, 0, 64'h0, 0, mk_e(64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 0, 0), "wr2");
    chk("wr2.plus4_zero", pc_plus4, 64'h0);
    step(0, 0, 64'h0, 0, mk_e(64'h0, 1, 1, 0, 0), "wr3");
    step(0, 0, 64'h0, 0, mk_e(64'h4, 1, 1, 0, 0), "wr4");
    do_reset("wr_rst");

    // 10 RUN, 2 STALL, 1 FLUSH, then halt: 11 accepted fetches.
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 64'h0, 0, mk_e(RST_PC + 64'(4 * i), 1, 1, 0, 0), $sformatf("cnt_run%0d", i));
    end
    step(1, 0, 64'h0,    0, mk_e(64'h1024, 1, 0, 0, 0), "cnt_st0");
    step(1, 0, 64'h0,    0, mk_e(64'h1024, 1, 0, 0, 0), "cnt_st1");
    step(0, 1, 64'h3000, 0, mk_e(64'h3000, 1, 1, 1, 0), "cnt_fl");
    step(0, 0, 64'h0,    1, mk_e(64'h3000, 0, 0, 0, 0), "cnt_halt");
`ifdef FETCH_CNT_EN
    chk("cnt_total", 64'(fetch_count), 64'd11);
`else
    chk("cnt_total", 64'(fetch_count), 64'd0);
`endif
    step(0, 0, 64'h0,    0, mk_e(64'h3000, 0, 0, 0, 0), "cnt_hold");
    do_reset("cnt_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter and fetch-control stage at the front of the 64-bit pipeline. It holds the fetch address and sequences it through boot, normal increment, stall, branch redirect with squash, and halt. Its outputs drive the instruction-memory address and the load-enable and squash inputs of the IF/ID pipeline register, which is built from enabled D flip-flop banks.

Parameters:
WIDTH, 64, address width in bits; must be >= 3
RESET_PC, 64'h0, fetch address loaded on reset; bits [1:0] must be 0
CNT_W, 32, width of the fetch performance counter

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hazard unit hold request; PC and IF/ID must not advance
br_taken  input  1  branch/jump resolved taken this cycle
br_target  input  WIDTH  redirect address, valid when br_taken=1
halt  input  1  stop fetching; sticky until reset
pc  output  WIDTH  current fetch address
pc_plus4  output  WIDTH  pc + 4, combinational, wraps modulo 2^WIDTH
fetch_valid  output  1  pc is a real fetch this cycle
ifid_en  output  1  load enable for the IF/ID register
squash  output  1  IF/ID must load a bubble this cycle
misalign  output  1  sticky error: br_target[1:0] != 0 was accepted
fetch_count  output  CNT_W  number of fetches accepted

Behaviour:
- Clock and reset are decided: one clock, clk. reset is asynchronous and active-high.
- All state updates on the rising edge of clk.
- On reset assertion, with no clock needed:
  - pc = RESET_PC and state = BOOT.
  - fetch_valid = 0, squash = 0, misalign = 0, fetch_count = 0.
  - ifid_en = 0.
- Reset asserted mid-operation (any state, including HALT) has the same effect immediately.
- FSM states: BOOT, RUN, STALL, FLUSH, HALT.
- BOOT: lasts exactly 1 cycle after reset deasserts.
  - fetch_valid = 0, ifid_en = 0, pc holds.
  - Next state: RUN. halt in this cycle instead goes to HALT.
- RUN, STALL and FLUSH evaluate inputs with fixed priority: halt > br_taken > stall > increment.
  - halt: next state HALT, pc holds.
  - br_taken with br_target[1:0] == 0: pc <= br_target, next state FLUSH.
  - br_taken with br_target[1:0] != 0: misalign <= 1, pc holds, next state HALT.
  - stall (no br_taken): pc holds, next state STALL.
  - otherwise: pc <= pc + 4, next state RUN.
- Outputs in RUN: fetch_valid = 1, ifid_en = 1, squash = 0.
- Outputs in STALL: fetch_valid = 1, ifid_en = 0, squash = 0.
  - Leaving STALL follows the same priority list.
  - A branch arriving during a stall is taken; stall is ignored in that cycle.
- FLUSH lasts 1 cycle, entered the cycle after an accepted branch.
  - squash = 1, ifid_en = 1, fetch_valid = 1; the fetch at the target is valid.
  - IF/ID loads a bubble in place of the wrong-path word already fetched.
  - stall in FLUSH: squash is still 1 that cycle; pc holds; next state STALL.
  - A back-to-back br_taken in FLUSH redirects again and stays in FLUSH.
- HALT: fetch_valid = 0, ifid_en = 0, squash = 0, pc frozen.
  - All inputs are ignored; only reset exits.
- Width and arithmetic:
  - pc increments by 4 modulo 2^WIDTH.
  - From 2^WIDTH-4, pc wraps to 0 with no error.
  - pc_plus4 is a pure function of pc.
- Latency: a redirect is visible on pc 1 cycle after br_taken is sampled.

Optional Feature:
FETCH_CNT_EN:
- Defined:
  - fetch_count increments by 1 on each rising edge where fetch_valid = 1 and ifid_en = 1.
  - It saturates at all-ones and does not wrap.
  - It is cleared only by reset.
- Undefined:
  - fetch_count is tied to 0 and no counter flops are instantiated.
  - All other behaviour is identical.

Test Plan:
1. Reset with RESET_PC=0x1000, then release -> BOOT for 1 cycle (fetch_valid=0); then pc = 0x1000, 0x1004, 0x1008 on successive cycles; fetch_valid=1, ifid_en=1.
2. At pc=0x1008 assert stall for 3 cycles -> pc stays 0x1008 and ifid_en=0 for 3 cycles; next cycle pc=0x100C.
3. At pc=0x2000 pulse br_taken with br_target=0x4000, stall also high -> next cycle pc=0x4000, squash=1 for exactly 1 cycle; following cycle pc=0x4004, squash=0.
4. br_taken with br_target=0x4002 -> misalign=1 the next cycle, state HALT, fetch_valid=0, pc unchanged; a further br_taken has no effect; reset clears misalign and restores pc=RESET_PC.
5. RESET_PC=0xFFFF_FFFF_FFFF_FFF8 -> pc = ...FFF8, ...FFFC, then 0x0; pc_plus4 = 0x0 while pc = ...FFFC.
6. With FETCH_CNT_EN defined, run 10 RUN cycles, 2 STALL cycles and 1 FLUSH cycle, then halt -> fetch_count = 11. Assert reset asynchronously between clock edges -> fetch_count = 0 and pc = RESET_PC before the next edge.
